bios_cmd_master: RTL

- Host-side initiator for the BIOS byte-command protocol.
- Accepts one command per handshake: opcode plus operands A, B, C.
- Serializes it as 4 bytes (opcode, A, B, C) onto a byte stream toward the BIOS.
- For READ, waits for the one-byte response with a timeout, then reports it.
- Used by the FPGA loader and the system bench to drive the BIOS over the UART byte path.

---
 rtl/bios_pkg.sv | 30 +++
 rtl/bios_rsp_timer.sv | 40 ++++
 rtl/bios_cmd_master.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bios_pkg.sv
// bios_pkg
// Shared types for the BIOS byte-command protocol: the opcode encoding
// (also imported by the BIOS-side parser), the host master FSM state type,
// and the fixed frame length in bytes.
// No ports (package).

package bios_pkg;

  typedef enum logic [7:0] {
    OP_NOP       = 8'd0,
    OP_BOOT      = 8'd1,
    OP_RST       = 8'd2,
    OP_ADR_LOWER = 8'd3,
    OP_ADR_UPPER = 8'd4,
    OP_WRITE     = 8'd5,
    OP_READ      = 8'd6
  } bios_opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_OP,
    S_SEND_A,
    S_SEND_B,
    S_SEND_C,
    S_WAIT_RSP
  } bios_master_state_t;

  localparam int BIOS_FRAME_BYTES = 4;

endpackage

// File: rtl/bios_rsp_timer.sv
// bios_rsp_timer
// Loadable up-counter used to time out a READ response.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear to 0 (highest priority)
//   load        synchronous load of load_val
//   load_val    value loaded when load=1
//   en          count-up enable
//   tc          terminal count: count == TIMEOUT_CYCLES-1

module bios_rsp_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bios_cmd_master.sv
// bios_cmd_master
// Host-side initiator for the BIOS byte-command protocol. Accepts one
// command (opcode, A, B, C) per handshake, serializes it as four bytes onto
// the output stream and, for READ, waits for a one-byte response with a
// timeout.
// Ports:
//   clk, rst_n, clk_en           clock, async active-low reset, clock enable
//   cmd_valid/cmd_ready          command handshake; cmd_opcode, cmd_a/b/c
//   o_data/o_valid/i_out_ready   byte stream toward the BIOS
//   i_data/i_valid/o_in_ready    response byte from the BIOS
//   rsp_valid/rsp_data/rsp_timeout  READ completion pulse
//   booted, busy                 status
//   cmd_count, timeout_count     statistics
// Optional feature: define BIOS_CMD_STATS_EN to build the saturating
// cmd_count / timeout_count counters; otherwise both ports are tied to 0.

module bios_cmd_master
  import bios_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [7:0]  cmd_c,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_out_ready,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_in_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_timeout,
  output logic        booted,
  output logic        busy,
  output logic [15:0] cmd_count,
  output logic [7:0]  timeout_count
);

  bios_master_state_t state;
  bios_opcode_t       op_q;
  logic [7:0]         a_q, b_q, c_q;
  logic [7:0]         o_data_q;
  logic               booted_q;
  logic               rsp_valid_q, rsp_timeout_q;
  logic [7:0]         rsp_data_q;
  logic               timer_tc;

  logic sending, accept, xfer, last_xfer, rsp_take, timeout_hit;

  // Handshake outputs are gated by clk_en so nothing can complete while frozen.
  assign sending     = (state inside {S_SEND_OP, S_SEND_A, S_SEND_B, S_SEND_C});
  assign o_valid     = clk_en & sending;
  assign cmd_ready   = clk_en & (state == S_IDLE) & ~booted_q;
  assign o_in_ready  = clk_en & (state == S_WAIT_RSP);
  assign accept      = cmd_valid & cmd_ready;
  assign xfer        = o_valid & i_out_ready;
  assign last_xfer   = xfer & (state == S_SEND_C);
  assign rsp_take    = i_valid & o_in_ready;
  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign timeout_hit = o_in_ready & ~i_valid & timer_tc;

  assign o_data      = o_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign booted      = booted_q;
  assign busy        = (state != S_IDLE);

  bios_rsp_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (last_xfer && (op_q == OP_READ)),
    .load     (1'b0),
    .load_val ('0),
    .en       (o_in_ready),
    .tc       (timer_tc)
  );

  // o_data is a register loaded one byte ahead, so it holds steady during
  // stalls and while clk_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= OP_NOP;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      o_data_q      <= '0;
      booted_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
    end else if (clk_en) begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= bios_opcode_t'(cmd_opcode);
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            c_q      <= cmd_c;
            o_data_q <= cmd_opcode;
            state    <= S_SEND_OP;
          end
        end
        S_SEND_OP: begin
          if (xfer) begin
            o_data_q <= a_q;
            state    <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          if (xfer) begin
            o_data_q <= b_q;
            state    <= S_SEND_B;
          end
        end
        S_SEND_B: begin
          if (xfer) begin
            o_data_q <= c_q;
            state    <= S_SEND_C;
          end
        end
        S_SEND_C: begin
          if (xfer) begin
            if (op_q == OP_READ) begin
              state <= S_WAIT_RSP;
            end else begin
              if (op_q == OP_BOOT) booted_q <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_WAIT_RSP: begin
          if (rsp_take) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= i_data;
            rsp_timeout_q <= 1'b0;
            state         <= S_IDLE;
          end else if (timeout_hit) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BIOS_CMD_STATS_EN
  logic [15:0] cmd_count_q;
  logic [7:0]  timeout_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_count_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      if (last_xfer && (cmd_count_q != 16'hFFFF)) cmd_count_q <= cmd_count_q + 1'b1;
      if (timeout_hit && (timeout_count_q != 8'hFF)) timeout_count_q <= timeout_count_q + 1'b1;
    end
  end

  assign cmd_count     = cmd_count_q;
  assign timeout_count = timeout_count_q;
`else
  assign cmd_count     = 16'd0;
  assign timeout_count = 8'd0;
`endif

endmodule
